// File: rtl/register_readback.sv
// Snapshot-and-stream readback for an observed register: captures I on REQ and shifts it out LSB-first
// over a 1-bit valid/ready link. Define READBACK_PARITY_EN to append an even-parity bit to each frame.
module register_readback #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I,
  input  logic             REQ,
  output logic             SO,
  output logic             SO_VALID,
  output logic             SO_LAST,
  input  logic             SO_READY,
  output logic             BUSY,
  output logic             OVERRUN
);

`ifdef READBACK_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic             req_prev_q, req_prev_d;
  logic             so_q, so_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

`ifdef READBACK_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  // Bit of the frame at position c: shadow bits first, then the optional parity bit.
  function automatic logic frame_bit(input logic [WIDTH-1:0] sh, input logic [CNT_W-1:0] c);
`ifdef READBACK_PARITY_EN
    if (c == LAST_CNT) begin
      return even_parity(sh);
    end else begin
      return |((sh >> c) & WIDTH'(1'b1));
    end
`else
    return |((sh >> c) & WIDTH'(1'b1));
`endif
  endfunction

  // Next-state and next-output computation; outputs are decoded from next state so they leave a flop.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    overrun_d  = overrun_q;
    req_prev_d = REQ;

    case (state_q)
      IDLE: begin
        if (REQ) begin
          shadow_d  = I;
          cnt_d     = {CNT_W{1'b0}};
          overrun_d = 1'b0;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Only a fresh 0->1 request counts as dropped; a level held over from the capture does not.
        if (REQ && !req_prev_q) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (SO_READY) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    if (state_d == SHIFT) begin
      so_d    = frame_bit(shadow_d, cnt_d);
      valid_d = 1'b1;
      last_d  = (cnt_d == LAST_CNT);
    end else begin
      so_d    = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q    <= IDLE;
      shadow_q   <= {WIDTH{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      overrun_q  <= 1'b0;
      req_prev_q <= 1'b0;
      so_q       <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      overrun_q  <= overrun_d;
      req_prev_q <= req_prev_d;
      so_q       <= so_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign SO       = so_q;
  assign SO_VALID = valid_q;
  assign SO_LAST  = last_q;
  assign BUSY     = valid_q;
  assign OVERRUN  = overrun_q;

endmodule
